// File: rtl/mem_port_scheduler_pkg.sv
// Shared definitions for the memory port scheduler: state and owner encodings,
// default timing parameters and the word-alignment helper.
package mem_port_scheduler_pkg;

    localparam int MEM_LATENCY = 2;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RMW_RD  = 3'd2,
        ST_RMW_WR  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/mem_port_scheduler_byte_lane_merge.sv
// Replaces one byte lane of a 32-bit word; used to build the write word of a
// read-modify-write byte store.
module mem_port_scheduler_byte_lane_merge (
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = word_i;
        case (lane_i)
            2'd0: merged_o[7:0]   = byte_i;
            2'd1: merged_o[15:8]  = byte_i;
            2'd2: merged_o[23:16] = byte_i;
            2'd3: merged_o[31:24] = byte_i;
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one single-ported word memory between fetch and data requesters;
// data has fixed priority and byte stores run as read-modify-write.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | arbitrate; grant drives mem_* combinationally this cycle
//  ST_RD_WAIT | load/fetch issued, waiting for mem_rvalid (timeout armed)
//  ST_RMW_RD  | byte-store read issued, waiting for old word (timeout armed)
//  ST_RMW_WR  | write merged word back
//  ST_DONE    | one-cycle ack to the recorded owner
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic        d_is_byte_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    output logic        err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic [31:0]      merge_q, merge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      merged;

    // Lane and store byte come straight from the data port, which is held until ack.
    mem_port_scheduler_byte_lane_merge u_merge (
        .word_i   (mem_rdata_i),
        .byte_i   (d_wdata_i[7:0]),
        .lane_i   (d_addr_i[1:0]),
        .merged_o (merged)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            merge_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            merge_q    <= merge_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        merge_d     = merge_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_ack_o    = 1'b0;
        d_ack_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if (d_req_i) begin
                    owner_d    = OWN_D;
                    mem_req_o  = 1'b1;
                    mem_addr_o = word_align(d_addr_i);
                    cnt_d      = '0;
                    if (d_we_i && !d_is_byte_i) begin
                        mem_we_o    = 1'b1;
                        mem_wdata_o = d_wdata_i;
                        state_d     = ST_DONE;
                    end else if (d_we_i) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else if (if_req_i) begin
                    owner_d    = OWN_IF;
                    mem_req_o  = 1'b1;
                    mem_addr_o = word_align(if_addr_i);
                    cnt_d      = '0;
                    state_d    = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT, ST_RMW_RD: begin
                if (mem_rvalid_i) begin
                    if (state_q == ST_RMW_RD) begin
                        merge_d = merged;
                        state_d = ST_RMW_WR;
                    end else begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = mem_rdata_i;
                        end else begin
                            d_rdata_d = mem_rdata_i;
                        end
                        state_d = ST_DONE;
                    end
                end else begin
                    // A timed-out operation is abandoned without an ack.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RMW_WR: begin
                if (mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = word_align(d_addr_i);
                mem_wdata_o = merge_q;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                if (mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if_ack_o = (owner_q == OWN_IF);
                d_ack_o  = (owner_q == OWN_D);
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign err_o      = err_q;

endmodule
